// File: rtl/dec_key_sched_ctrl_if.sv
// Handshake bundle between the decryption key scheduler and its datapath:
// key loading, status, and the reverse-order round-key stream.
interface dec_key_sched_ctrl_if #(
   parameter int unsigned BLOCK_LENGTH = 128
);
   logic                    key_load;
   logic [BLOCK_LENGTH-1:0] key_in;
   logic                    busy;
   logic                    keys_ready;
   logic                    rk_req;
   logic                    rk_valid;
   logic [BLOCK_LENGTH-1:0] rk_data;
   logic [3:0]              rk_round;
   logic                    blk_last;

   modport master (
      output key_load, key_in, rk_req,
      input  busy, keys_ready, rk_valid, rk_data, rk_round, blk_last
   );

   modport slave (
      input  key_load, key_in, rk_req,
      output busy, keys_ready, rk_valid, rk_data, rk_round, blk_last
   );
endinterface

// File: rtl/dec_key_sched_ctrl.sv
// Runs the forward AES-128 key expansion once per loaded key, stores K0..K10,
// then serves them K10 first down to K0, one key per request, reusing the set per block.
module dec_key_sched_ctrl #(
   parameter int unsigned BLOCK_LENGTH = 128,
   parameter int unsigned NUM_ROUNDS   = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   dec_key_sched_ctrl_if.slave     bus,
   output logic                    kg_en,
   output logic [3:0]              kg_round,
   output logic [BLOCK_LENGTH-1:0] kg_key,
   input  logic [BLOCK_LENGTH-1:0] kg_cur_key
);
   localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

   typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [3:0]              issue_cnt;
   logic                    cap_vld;
   logic [3:0]              cap_idx;
   logic [3:0]              rd_ptr;
   logic [BLOCK_LENGTH-1:0] store [0:NUM_ROUNDS];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.key_load) state_nxt = EXPAND;
         EXPAND:  if (!bus.key_load && cap_vld && (cap_idx == LAST)) state_nxt = READY;
         READY:   if (bus.key_load) state_nxt = EXPAND;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy       = (state == EXPAND);
      bus.keys_ready = (state == READY);
      kg_en          = (state == EXPAND) && (issue_cnt <= LAST);
      kg_round       = kg_en ? issue_cnt : '0;
   end

   // The generator output lags its issue by one cycle, so capture uses the delayed index.
   always_ff @(posedge clk) begin
      if (!rst && cap_vld && (state == EXPAND)) store[cap_idx] <= kg_cur_key;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         kg_key       <= '0;
         issue_cnt    <= '0;
         cap_vld      <= 1'b0;
         cap_idx      <= '0;
         rd_ptr       <= LAST;
         bus.rk_valid <= 1'b0;
         bus.rk_data  <= '0;
         bus.rk_round <= '0;
         bus.blk_last <= 1'b0;
      end else begin
         bus.rk_valid <= 1'b0;
         bus.blk_last <= 1'b0;
         cap_vld      <= kg_en;
         cap_idx      <= issue_cnt;
         if (kg_en) issue_cnt <= issue_cnt + 4'd1;
         if ((state == EXPAND) && (state_nxt == READY)) rd_ptr <= LAST;

         // A new key pre-empts everything, including a same-cycle request.
         if (bus.key_load) begin
            kg_key    <= bus.key_in;
            issue_cnt <= '0;
            cap_vld   <= 1'b0;
            rd_ptr    <= LAST;
         end else if ((state == READY) && bus.rk_req) begin
            bus.rk_valid <= 1'b1;
            bus.rk_data  <= store[rd_ptr];
            bus.rk_round <= rd_ptr;
            bus.blk_last <= (rd_ptr == '0);
            rd_ptr       <= (rd_ptr == '0) ? LAST : rd_ptr - 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_dec_key_sched_ctrl.sv
// Bench for dec_key_sched_ctrl: models key_generator_dec with a behavioural AES-128
// key expansion and checks load latency, reverse-order serving, pre-emption and reset.
module tb_dec_key_sched_ctrl;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         kg_en;
   logic [3:0]   kg_round;
   logic [127:0] kg_key;
   logic [127:0] kg_cur_key = '0;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] sbox_tab [256];

   dec_key_sched_ctrl_if #(.BLOCK_LENGTH(128)) bus ();

   dec_key_sched_ctrl #(.BLOCK_LENGTH(128), .NUM_ROUNDS(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .kg_en      (kg_en),
      .kg_round   (kg_round),
      .kg_key     (kg_key),
      .kg_cur_key (kg_cur_key)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] t;
      logic [7:0] s;
      for (int v = 0; v < 256; v++) begin
         inv = '0;
         if (v != 0) begin
            inv = 8'h01;
            repeat (254) inv = gmul(inv, 8'(v));
         end
         s = inv;
         t = inv;
         for (int k = 0; k < 4; k++) begin
            t = {t[6:0], t[7]};
            s ^= t;
         end
         sbox_tab[v] = s ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
            t ^= {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   // key_generator_dec stand-in: registered round key one cycle after each enabled request.
   always @(posedge clk) begin
      if (kg_en) kg_cur_key <= round_key(kg_key, int'(kg_round));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [127:0] k);
      bus.key_load = 1'b1;
      bus.key_in   = k;
      step();
      bus.key_load = 1'b0;
   endtask

   task automatic wait_ready(output int lat);
      lat = 0;
      while (!bus.keys_ready && lat < 40) begin
         step();
         lat++;
      end
   endtask

   function automatic logic [127:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic test_reset();
      logic [7:0] ctl;
      rst = 1'b1;
      step();
      step();
      ctl = {bus.busy, bus.keys_ready, kg_en, kg_round, bus.rk_valid, bus.blk_last};
      n_cmp++;
      if (ctl !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_ctl: got %h expected 00", ctl);
      end
      n_cmp++;
      if ({kg_key, bus.rk_data, bus.rk_round} !== '0) begin
         n_bad++;
         $display("FAIL reset_data: kg_key %h rk_data %h rk_round %0d expected all 0", kg_key, bus.rk_data, bus.rk_round);
      end
      rst = 1'b0;
      bus.rk_req = 1'b1;
      step();
      bus.rk_req = 1'b0;
      n_cmp++;
      if (bus.rk_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_req_ignored: rk_valid %b expected 0", bus.rk_valid);
      end
   endtask

   task automatic test_fips_c1();
      logic [127:0] k;
      logic [127:0] first_d;
      logic [127:0] last_d;
      logic [6:0]   got_s;
      logic [6:0]   exp_s;
      k = 128'h000102030405060708090a0b0c0d0e0f;
      do_load(k);
      n_cmp++;
      if (kg_key !== k) begin
         n_bad++;
         $display("FAIL c1_kg_key: got %h expected %h", kg_key, k);
      end
      // Cycle-by-cycle issue schedule; ready must appear after edge 12 (13 edges incl. load).
      for (int c = 0; c <= 12; c++) begin
         if (c > 0) step();
         got_s = {bus.busy, bus.keys_ready, kg_en, kg_round};
         exp_s = {(c < 12) ? 1'b1 : 1'b0, (c == 12) ? 1'b1 : 1'b0, (c <= 10) ? 1'b1 : 1'b0,
                  (c <= 10) ? 4'(c) : 4'd0};
         n_cmp++;
         if (got_s !== exp_s) begin
            n_bad++;
            $display("FAIL c1_expand_c%0d: {busy,ready,en,round} got %b expected %b", c, got_s, exp_s);
         end
      end
      first_d = '0;
      last_d  = '0;
      bus.rk_req = 1'b1;
      for (int j = 0; j < 11; j++) begin
         step();
         n_cmp++;
         if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'(10 - j) || bus.blk_last !== (j == 10)
             || bus.rk_data !== round_key(k, 10 - j)) begin
            n_bad++;
            $display("FAIL c1_serve_%0d: valid %b round %0d last %b data %h expected 1 %0d %b %h",
                     j, bus.rk_valid, bus.rk_round, bus.blk_last, bus.rk_data, 10 - j, j == 10,
                     round_key(k, 10 - j));
         end
         if (j == 0)  first_d = bus.rk_data;
         if (j == 10) last_d  = bus.rk_data;
      end
      bus.rk_req = 1'b0;
      n_cmp++;
      if (first_d !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
         n_bad++;
         $display("FAIL c1_k10_const: got %h expected 13111d7fe3944a17f307a78b4d2b30c5", first_d);
      end
      n_cmp++;
      if (last_d !== k) begin
         n_bad++;
         $display("FAIL c1_k0_const: got %h expected %h", last_d, k);
      end
      step();
      n_cmp++;
      if (bus.rk_valid !== 1'b0 || bus.rk_data !== k) begin
         n_bad++;
         $display("FAIL c1_hold: valid %b data %h expected 0 %h", bus.rk_valid, bus.rk_data, k);
      end
   endtask

   task automatic test_two_sequences();
      logic [127:0] k;
      logic [127:0] seq1 [11];
      logic [127:0] seq2 [11];
      logic [3:0]   r2_first;
      int           lat;
      k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      do_load(k);
      wait_ready(lat);
      n_cmp++;
      if (lat + 1 != 13) begin
         n_bad++;
         $display("FAIL a1_latency: got %0d expected 13", lat + 1);
      end
      bus.rk_req = 1'b1;
      step();
      bus.rk_req = 1'b0;
      n_cmp++;
      if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'd10 || bus.rk_data !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
         n_bad++;
         $display("FAIL a1_k10: valid %b round %0d data %h expected 1 10 d014f9a8c9ee2589e13f0cc8b6630ca6",
                  bus.rk_valid, bus.rk_round, bus.rk_data);
      end
      bus.rk_req = 1'b1;
      repeat (10) step();
      n_cmp++;
      if (bus.blk_last !== 1'b1 || bus.rk_round !== 4'd0) begin
         n_bad++;
         $display("FAIL a1_finish_block: last %b round %0d expected 1 0", bus.blk_last, bus.rk_round);
      end
      r2_first = '1;
      for (int j = 0; j < 22; j++) begin
         step();
         if (j < 11) seq1[j] = bus.rk_data;
         else        seq2[j-11] = bus.rk_data;
         if (j == 11) r2_first = bus.rk_round;
      end
      bus.rk_req = 1'b0;
      step();
      n_cmp++;
      if (r2_first !== 4'd10) begin
         n_bad++;
         $display("FAIL a1_seq2_start: round %0d expected 10", r2_first);
      end
      for (int j = 0; j < 11; j++) begin
         n_cmp++;
         if (seq1[j] !== round_key(k, 10 - j) || seq2[j] !== seq1[j]) begin
            n_bad++;
            $display("FAIL a1_seq_%0d: first %h second %h expected %h", j, seq1[j], seq2[j], round_key(k, 10 - j));
         end
      end
   endtask

   task automatic test_req_during_expand();
      logic [127:0] k;
      int           bad_v;
      k = rand_key();
      do_load(k);
      bad_v = 0;
      for (int c = 1; c <= 12; c++) begin
         bus.rk_req = 1'($urandom_range(0, 1));
         step();
         if (bus.rk_valid !== 1'b0) bad_v++;
      end
      bus.rk_req = 1'b0;
      n_cmp++;
      if (bad_v != 0) begin
         n_bad++;
         $display("FAIL expand_req_valid: %0d rk_valid pulses expected 0", bad_v);
      end
      n_cmp++;
      if (bus.keys_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL expand_ready: keys_ready %b expected 1", bus.keys_ready);
      end
      bus.rk_req = 1'b1;
      step();
      bus.rk_req = 1'b0;
      n_cmp++;
      if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'd10 || bus.rk_data !== round_key(k, 10)) begin
         n_bad++;
         $display("FAIL expand_first_req: valid %b round %0d data %h expected 1 10 %h",
                  bus.rk_valid, bus.rk_round, bus.rk_data, round_key(k, 10));
      end
   endtask

   task automatic test_load_preempt();
      logic [127:0] ka;
      logic [127:0] kb;
      int           lat;
      ka = rand_key();
      kb = rand_key();
      do_load(ka);
      wait_ready(lat);
      bus.rk_req = 1'b1;
      for (int j = 0; j < 5; j++) begin
         step();
         n_cmp++;
         if (bus.rk_round !== 4'(10 - j) || bus.rk_data !== round_key(ka, 10 - j)) begin
            n_bad++;
            $display("FAIL preempt_serve_%0d: round %0d data %h expected %0d %h",
                     j, bus.rk_round, bus.rk_data, 10 - j, round_key(ka, 10 - j));
         end
      end
      bus.key_load = 1'b1;
      bus.key_in   = kb;
      step();
      bus.key_load = 1'b0;
      bus.rk_req   = 1'b0;
      n_cmp++;
      if ({bus.rk_valid, bus.keys_ready, bus.busy} !== 3'b001) begin
         n_bad++;
         $display("FAIL preempt_drop: {valid,ready,busy} %b expected 001", {bus.rk_valid, bus.keys_ready, bus.busy});
      end
      wait_ready(lat);
      n_cmp++;
      if (lat + 1 != 13) begin
         n_bad++;
         $display("FAIL preempt_latency: got %0d expected 13", lat + 1);
      end
      bus.rk_req = 1'b1;
      step();
      bus.rk_req = 1'b0;
      n_cmp++;
      if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'd10 || bus.rk_data !== round_key(kb, 10)) begin
         n_bad++;
         $display("FAIL preempt_new_k10: valid %b round %0d data %h expected 1 10 %h",
                  bus.rk_valid, bus.rk_round, bus.rk_data, round_key(kb, 10));
      end
   endtask

   task automatic test_double_load();
      logic [127:0] ka;
      logic [127:0] kb;
      int           lat;
      ka = rand_key();
      kb = rand_key();
      do_load(ka);
      repeat (4) step();
      do_load(kb);
      wait_ready(lat);
      n_cmp++;
      if (lat + 1 != 13) begin
         n_bad++;
         $display("FAIL reload_latency: got %0d expected 13", lat + 1);
      end
      bus.rk_req = 1'b1;
      for (int j = 0; j < 11; j++) begin
         step();
         n_cmp++;
         if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'(10 - j) || bus.rk_data !== round_key(kb, 10 - j)) begin
            n_bad++;
            $display("FAIL reload_serve_%0d: valid %b round %0d data %h expected 1 %0d %h",
                     j, bus.rk_valid, bus.rk_round, bus.rk_data, 10 - j, round_key(kb, 10 - j));
         end
      end
      bus.rk_req = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      logic [127:0] k;
      int           lat;
      int           bad_v;
      for (int pass = 0; pass < 2; pass++) begin
         k = rand_key();
         do_load(k);
         if (pass == 0) begin
            repeat (4) step();
         end else begin
            wait_ready(lat);
            bus.rk_req = 1'b1;
            repeat (3) step();
            bus.rk_req = 1'b0;
         end
         rst = 1'b1;
         step();
         rst = 1'b0;
         n_cmp++;
         if ({bus.busy, bus.keys_ready, kg_en, kg_round, bus.rk_valid, bus.blk_last, bus.rk_round} !== '0
             || kg_key !== '0 || bus.rk_data !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_%0d: busy %b ready %b en %b round %0d valid %b last %b kg_key %h data %h expected all 0",
                     pass, bus.busy, bus.keys_ready, kg_en, kg_round, bus.rk_valid, bus.blk_last, kg_key, bus.rk_data);
         end
         bad_v = 0;
         bus.rk_req = 1'b1;
         repeat (15) begin
            step();
            if (bus.rk_valid !== 1'b0 || bus.keys_ready !== 1'b0) bad_v++;
         end
         bus.rk_req = 1'b0;
         n_cmp++;
         if (bad_v != 0) begin
            n_bad++;
            $display("FAIL mid_reset_ignore_%0d: %0d active cycles expected 0", pass, bad_v);
         end
      end
      k = rand_key();
      do_load(k);
      wait_ready(lat);
      n_cmp++;
      if (lat + 1 != 13) begin
         n_bad++;
         $display("FAIL post_reset_latency: got %0d expected 13", lat + 1);
      end
      bus.rk_req = 1'b1;
      step();
      bus.rk_req = 1'b0;
      n_cmp++;
      if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'd10 || bus.rk_data !== round_key(k, 10)) begin
         n_bad++;
         $display("FAIL post_reset_k10: valid %b round %0d data %h expected 1 10 %h",
                  bus.rk_valid, bus.rk_round, bus.rk_data, round_key(k, 10));
      end
   endtask

   // Reference model: a load arms a 12-edge countdown to ready; then each accepted
   // request yields key index ptr, counting 10 down to 0 and wrapping.
   task automatic test_random();
      logic [127:0] mkey;
      logic [127:0] nk;
      logic [127:0] ed;
      logic [127:0] last_d;
      bit           ld;
      bit           req;
      bit           ready;
      bit           ev;
      bit           el;
      bit           seen;
      int           ptr;
      int           er;
      int           cd;
      mkey   = '0;
      last_d = '0;
      ready  = 1'b0;
      seen   = 1'b0;
      ptr    = 10;
      cd     = 0;
      for (int n = 0; n < 300; n++) begin
         ld  = (n == 0) || ($urandom_range(0, 99) < 3);
         req = 1'($urandom_range(0, 1));
         nk  = rand_key();
         bus.key_load = ld;
         bus.key_in   = nk;
         bus.rk_req   = req;
         step();
         bus.key_load = 1'b0;
         bus.rk_req   = 1'b0;
         ev = 1'b0;
         el = 1'b0;
         er = 0;
         ed = '0;
         if (ld) begin
            mkey  = nk;
            ready = 1'b0;
            cd    = 12;
            ptr   = 10;
         end else if (ready) begin
            if (req) begin
               ev  = 1'b1;
               er  = ptr;
               ed  = round_key(mkey, ptr);
               el  = (ptr == 0);
               ptr = (ptr == 0) ? 10 : ptr - 1;
            end
         end else begin
            cd--;
            if (cd == 0) ready = 1'b1;
         end
         n_cmp++;
         if (bus.rk_valid !== ev || bus.keys_ready !== ready || bus.busy !== !ready) begin
            n_bad++;
            $display("FAIL rand_status_%0d: valid %b ready %b busy %b expected %b %b %b",
                     n, bus.rk_valid, bus.keys_ready, bus.busy, ev, ready, !ready);
         end
         if (ev) begin
            n_cmp++;
            if (bus.rk_round !== 4'(er) || bus.rk_data !== ed || bus.blk_last !== el) begin
               n_bad++;
               $display("FAIL rand_key_%0d: round %0d data %h last %b expected %0d %h %b",
                        n, bus.rk_round, bus.rk_data, bus.blk_last, er, ed, el);
            end
            last_d = ed;
            seen   = 1'b1;
         end else if (seen) begin
            n_cmp++;
            if (bus.rk_data !== last_d || bus.blk_last !== 1'b0) begin
               n_bad++;
               $display("FAIL rand_hold_%0d: data %h last %b expected %h 0", n, bus.rk_data, bus.blk_last, last_d);
            end
         end
      end
   endtask

   initial begin
      bus.key_load = 1'b0;
      bus.key_in   = '0;
      bus.rk_req   = 1'b0;
      build_sbox();
      test_reset();
      test_fips_c1();
      test_two_sequences();
      test_req_during_expand();
      test_load_preempt();
      test_double_load();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, %0d compared so far", n_cmp);
      $fatal(1, "time limit");
   end
endmodule
